// File: rtl/boot_mem_ctrl.sv
// rtl/boot_mem_ctrl.sv - CPU memory request controller for debug ROM / SPI memory boot sources
// Optional SPI wait timeout: define BOOT_MEM_TIMEOUT_EN.
module boot_mem_ctrl #(
    parameter int ROM_SIZE = 25,
    parameter int TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        boot_sel,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ready,
    output logic [7:0]  rom_addr,
    input  logic [7:0]  rom_data,
    output logic        spi_start,
    output logic        spi_we,
    output logic [15:0] spi_addr,
    output logic [7:0]  spi_wdata,
    input  logic [7:0]  spi_rdata,
    input  logic        spi_done,
    output logic        boot_mode,
    output logic        err_timeout
);

    typedef enum logic [2:0] {IDLE, ROM_RD, SPI_GO, SPI_WAIT, RESP} state_t;

    localparam logic [15:0] ROM_LIMIT = 16'(ROM_SIZE);

    state_t      state;
    state_t      state_nxt;
    logic        latch_done;
    logic [15:0] addr_q;
    logic        we_q;
    logic        accept;
    logic        timeout_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        spi_start = 1'b0;
        cpu_ready = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req && latch_done) begin
                    accept = 1'b1;
                    if (!boot_mode)  state_nxt = SPI_GO;
                    else if (cpu_we) state_nxt = RESP;
                    else             state_nxt = ROM_RD;
                end
            end
            ROM_RD: state_nxt = RESP;
            SPI_GO: begin
                spi_start = 1'b1;
                // A completion arriving alongside the start pulse is accepted immediately.
                state_nxt = spi_done ? RESP : SPI_WAIT;
            end
            SPI_WAIT: begin
                if (spi_done || timeout_hit) state_nxt = RESP;
            end
            RESP: begin
                cpu_ready = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latch_done <= 1'b0;
            boot_mode  <= 1'b0;
            addr_q     <= 16'h0000;
            we_q       <= 1'b0;
            cpu_rdata  <= 8'h00;
            rom_addr   <= 8'h00;
            spi_we     <= 1'b0;
            spi_addr   <= 16'h0000;
            spi_wdata  <= 8'h00;
        end else begin
            if (!latch_done) begin
                boot_mode  <= boot_sel;
                latch_done <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q <= cpu_addr;
                        we_q   <= cpu_we;
                        if (boot_mode) begin
                            if (!cpu_we) rom_addr <= cpu_addr[7:0];
                        end else begin
                            spi_addr  <= cpu_addr;
                            spi_we    <= cpu_we;
                            spi_wdata <= cpu_wdata;
                        end
                    end
                end
                // Full 16-bit compare: aliases above the ROM image read as NOP.
                ROM_RD: cpu_rdata <= (addr_q < ROM_LIMIT) ? rom_data : 8'h00;
                SPI_GO, SPI_WAIT: begin
                    if (spi_done) begin
                        if (!we_q) cpu_rdata <= spi_rdata;
                    end else if (timeout_hit) begin
                        cpu_rdata <= 8'hFF;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BOOT_MEM_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] wait_cnt;
    logic       err_q;

    assign timeout_hit = (state == SPI_WAIT) && !spi_done && (wait_cnt == TIMEOUT_LAST);
    assign err_timeout = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 8'h00;
            err_q    <= 1'b0;
        end else begin
            if (accept)                 wait_cnt <= 8'h00;
            else if (state == SPI_WAIT) wait_cnt <= wait_cnt + 8'h01;
            if (timeout_hit)            err_q    <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT == 0);
    assign timeout_hit    = 1'b0;
    assign err_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_boot_mem_ctrl.sv
// tb/tb_boot_mem_ctrl.sv - randomized self-checking bench for boot_mem_ctrl
module tb_boot_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        boot_sel = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_data;
    logic        spi_start;
    logic        spi_we;
    logic [15:0] spi_addr;
    logic [7:0]  spi_wdata;
    logic [7:0]  spi_rdata = 8'h00;
    logic        spi_done = 1'b0;
    logic        boot_mode;
    logic        err_timeout;

    logic [7:0] rom [0:255];
    logic [7:0] mem [0:65535];

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int cur_delay = 0;
    bit resp_en = 1'b1;

    logic        exp_mode = 1'b0;
    logic [7:0]  exp_rd = 8'h00;
    logic        exp_err = 1'b0;
    logic [15:0] exp_addr = 16'h0000;
    logic        exp_we = 1'b0;
    logic [7:0]  exp_wdata = 8'h00;

    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    boot_mem_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .boot_sel    (boot_sel),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ready   (cpu_ready),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .spi_start   (spi_start),
        .spi_we      (spi_we),
        .spi_addr    (spi_addr),
        .spi_wdata   (spi_wdata),
        .spi_rdata   (spi_rdata),
        .spi_done    (spi_done),
        .boot_mode   (boot_mode),
        .err_timeout (err_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // SPI memory device: answers each start after cur_delay cycles (0 = same cycle as start).
    always begin
        @(posedge clk);
        #1;
        if (spi_start) begin
            start_cnt++;
            chk("spi_addr", {16'h0, spi_addr}, {16'h0, exp_addr});
            chk("spi_we", {31'h0, spi_we}, {31'h0, exp_we});
            if (exp_we) chk("spi_wdata", {24'h0, spi_wdata}, {24'h0, exp_wdata});
            if (resp_en) begin
                repeat (cur_delay) begin
                    @(posedge clk);
                    #1;
                end
                chk("spi_addr_held", {16'h0, spi_addr}, {16'h0, exp_addr});
                spi_rdata = mem[spi_addr];
                if (spi_we) mem[spi_addr] = spi_wdata;
                spi_done = 1'b1;
                @(posedge clk);
                #1;
                spi_done  = 1'b0;
                spi_rdata = 8'($urandom);
            end
        end
    end

    task automatic do_reset(input logic sel);
        reset    = 1'b1;
        boot_sel = sel;
        cpu_req  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", {24'h0, cpu_rdata}, 32'h0);
        chk("rst_ready", {31'h0, cpu_ready}, 32'h0);
        chk("rst_start", {31'h0, spi_start}, 32'h0);
        chk("rst_rom_addr", {24'h0, rom_addr}, 32'h0);
        chk("rst_spi", {7'h0, spi_we, spi_addr, spi_wdata}, 32'h0);
        chk("rst_mode_err", {30'h0, boot_mode, err_timeout}, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp_mode = sel;
        exp_rd   = 8'h00;
        exp_err  = 1'b0;
        chk("boot_mode_latch", {31'h0, boot_mode}, {31'h0, sel});
    endtask

    // d >= 0: SPI completes d cycles after start; d < 0: SPI never answers.
    task automatic run_txn(input logic we, input logic [15:0] addr, input logic [7:0] wdata, input int d);
        int k;
        int lat;
        int s0;
        bit got;
        exp_addr  = addr;
        exp_we    = we;
        exp_wdata = wdata;
        cur_delay = (d < 0) ? 0 : d;
        resp_en   = (d >= 0);
        s0        = start_cnt;
        if (exp_mode) begin
            lat = we ? 1 : 2;
            if (!we) exp_rd = (addr < 16'd25) ? rom[addr[7:0]] : 8'h00;
        end else if (d < 0) begin
            lat     = 2 + 255;
            exp_rd  = 8'hFF;
            exp_err = 1'b1;
        end else begin
            lat = 2 + d;
            if (!we) exp_rd = mem[addr];
        end
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        k   = 0;
        got = 1'b0;
        while (!got && k < 400) begin
            @(posedge clk);
            #1;
            k++;
            if (cpu_ready) got = 1'b1;
        end
        cpu_req = 1'b0;
        chk("latency", k, lat);
        chk("rdata", {24'h0, cpu_rdata}, {24'h0, exp_rd});
        chk("start_count", start_cnt - s0, exp_mode ? 0 : 1);
        chk("err_timeout", {31'h0, err_timeout}, {31'h0, exp_err});
        @(posedge clk);
        #1;
        chk("ready_pulse", {31'h0, cpu_ready}, 32'h0);
        chk("rdata_hold", {24'h0, cpu_rdata}, {24'h0, exp_rd});
        resp_en = 1'b1;
    endtask

    function automatic logic [15:0] rom_rand_addr();
        case ($urandom_range(0, 3))
            0, 1:    return 16'($urandom_range(0, 30));
            2:       return 16'($urandom_range(0, 255));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        rom[0]  = 8'hE0;
        rom[24] = 8'h00;
        rom[25] = 8'h77;
        mem[16'h1234] = 8'hA5;

        do_reset(1'b1);
        boot_sel = 1'b0;
        run_txn(1'b0, 16'h0000, 8'h00, 0);
        run_txn(1'b0, 16'h0018, 8'h00, 0);
        run_txn(1'b0, 16'h0019, 8'h00, 0);
        run_txn(1'b0, 16'h0100, 8'h00, 0);
        run_txn(1'b1, 16'h0005, 8'h55, 0);
        run_txn(1'b0, 16'h0003, 8'h00, 0);
        for (int i = 0; i < 40; i++)
            run_txn(($urandom_range(0, 3) == 0), rom_rand_addr(), 8'($urandom), 0);
        chk("boot_mode_frozen_rom", {31'h0, boot_mode}, 32'h1);

        do_reset(1'b0);
        run_txn(1'b0, 16'h1234, 8'h00, 3);
        run_txn(1'b1, 16'h0007, 8'h3C, 0);
        run_txn(1'b0, 16'h0007, 8'h00, 1);
        for (int i = 0; i < 40; i++)
            run_txn(($urandom_range(0, 1) == 0),
                    ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom),
                    8'($urandom), $urandom_range(0, 4));
        boot_sel = 1'b1;
        @(posedge clk);
        #1;
        chk("boot_mode_frozen_spi", {31'h0, boot_mode}, 32'h0);

`ifdef BOOT_MEM_TIMEOUT_EN
        run_txn(1'b0, 16'h4321, 8'h00, -1);
        run_txn(1'b0, 16'h0002, 8'h00, 2);
        chk("err_sticky", {31'h0, err_timeout}, 32'h1);
`endif

        exp_addr = 16'h2222;
        exp_we   = 1'b0;
        resp_en  = 1'b0;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h2222;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        chk("midrst_start", {31'h0, spi_start}, 32'h0);
        chk("midrst_outs", {cpu_rdata, 6'h0, boot_mode, err_timeout, spi_addr}, 32'h0);
        cpu_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("midrst_no_ready", {31'h0, cpu_ready}, 32'h0);
        end
        resp_en = 1'b1;
        do_reset(1'b1);
        run_txn(1'b0, 16'h0000, 8'h00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/boot_mem_ctrl.md
Name: boot_mem_ctrl

Overview:
- Memory-request controller between the NEANDER-X CPU memory port and its two backing stores: the 25-byte debug ROM and the external SPI memory controller.
- Boot source is latched from boot_sel after reset.
  - ROM mode: CPU reads are served from the debug ROM.
  - SPI mode: reads and writes are sequenced into the SPI controller with a start/done handshake.
- CPU sees one uniform req/ready protocol regardless of source.

Parameters:
- ROM_SIZE, 25, number of valid debug ROM bytes; ROM-mode reads at or above this address return 0x00 (NOP).
- TIMEOUT, 255, max cycles spent in SPI_WAIT before the transaction is aborted (optional feature only).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- boot_sel  input  1  boot source select (1 = debug ROM, 0 = SPI memory)
- cpu_req  input  1  CPU memory request; held high until cpu_ready
- cpu_we  input  1  1 = write, 0 = read; valid with cpu_req
- cpu_addr  input  16  CPU byte address
- cpu_wdata  input  8  CPU write data
- cpu_rdata  output  8  read data; valid while cpu_ready=1, held afterwards
- cpu_ready  output  1  one-cycle transaction-complete pulse
- rom_addr  output  8  debug ROM address (registered)
- rom_data  input  8  debug ROM combinational data
- spi_start  output  1  one-cycle SPI transaction start pulse
- spi_we  output  1  SPI write enable, held from start until done
- spi_addr  output  16  SPI address, held from start until done
- spi_wdata  output  8  SPI write data, held from start until done
- spi_rdata  input  8  SPI read data, valid when spi_done=1
- spi_done  input  1  one-cycle SPI completion pulse
- boot_mode  output  1  latched boot source
- err_timeout  output  1  sticky SPI timeout flag

Behaviour:
- Reset values:
  - state = IDLE
  - cpu_rdata = 0x00, cpu_ready = 0
  - rom_addr = 0x00
  - spi_start = 0, spi_we = 0, spi_addr = 0x0000, spi_wdata = 0x00
  - boot_mode = 0, err_timeout = 0
  - latch_done = 0
- Boot latch:
  - On the first clk edge after reset deasserts, boot_mode <= boot_sel and latch_done <= 1.
  - boot_mode is frozen until the next reset. boot_sel changes afterwards are ignored.
  - No request is accepted while latch_done = 0.
- States: IDLE, ROM_RD, SPI_GO, SPI_WAIT, RESP.
- IDLE, with cpu_req=1 and latch_done=1, captures cpu_addr, cpu_we and cpu_wdata, then:
  - boot_mode=1, read: rom_addr <= cpu_addr[7:0]; go to ROM_RD.
  - boot_mode=1, write: the write is discarded; go to RESP with cpu_rdata unchanged.
  - boot_mode=0: load spi_addr, spi_we and spi_wdata; go to SPI_GO.
- ROM_RD:
  - cpu_rdata <= (captured addr < ROM_SIZE) ? rom_data : 0x00. Upper address bits count in the comparison.
  - Go to RESP.
- SPI_GO: spi_start=1 for exactly this cycle; go to SPI_WAIT.
- SPI_WAIT:
  - On spi_done: cpu_rdata <= spi_rdata for reads (unchanged for writes); go to RESP.
  - A spi_done arriving in the SPI_GO cycle is also honoured: it completes the transaction and SPI_WAIT is skipped.
- RESP: cpu_ready=1 for this single cycle; go to IDLE.
  - The request is sampled again in IDLE, so a req held high gives back-to-back transactions.
- Latency, counted from the cycle cpu_req is sampled in IDLE (cycle N):
  - ROM read: ready at N+2.
  - ROM write: ready at N+1.
  - SPI: ready in the cycle after spi_done. Minimum is N+3 when done arrives in the SPI_WAIT cycle; N+2 when done arrives in the SPI_GO cycle.
- spi_done outside SPI_GO/SPI_WAIT is ignored.
- Reset asserted mid-transaction:
  - All state is cleared immediately (asynchronous). spi_start is dropped; no cpu_ready is issued.
  - The SPI controller is reset by the same reset.

Optional Feature:
- Macro: BOOT_MEM_TIMEOUT_EN.
- With the macro:
  - An 8-bit counter clears on entry to SPI_GO and increments each SPI_WAIT cycle.
  - When it reaches TIMEOUT with no spi_done: cpu_rdata <= 0xFF, err_timeout <= 1 (sticky until reset), go to RESP.
  - If spi_done and the timeout coincide, spi_done wins and err_timeout is not set.
- Without the macro: SPI_WAIT waits indefinitely, err_timeout is tied to 0, and no counter is synthesized.

Test Plan:
- ROM boot: boot_sel=1 through reset release, read addr 0x0000 with rom_data=0xE0 -> boot_mode=1; cpu_ready at N+2; cpu_rdata=0xE0.
- ROM bounds: boot_mode=1, read 0x0018 (rom_data=0x00) then 0x0019 and 0x0100 -> ready each; cpu_rdata=0x00 for 0x0019 and 0x0100 regardless of rom_data.
- ROM write: boot_mode=1, write 0x0005 data 0x55 -> ready at N+1; cpu_rdata unchanged; spi_start never pulses.
- SPI read: boot_sel=0, read 0x1234, spi_done 3 cycles after spi_start with spi_rdata=0xA5 -> single spi_start with spi_addr=0x1234, spi_we=0; cpu_ready one cycle after spi_done; cpu_rdata=0xA5.
- Boot latch: boot_sel toggles 1->0 after latch, then read 0x0003 -> still served by the ROM, spi_start stays 0.
- Timeout (BOOT_MEM_TIMEOUT_EN): SPI read with no spi_done -> cpu_ready after 255 wait cycles; cpu_rdata=0xFF; err_timeout=1 and held until reset. A mid-wait reset instead clears all outputs with no cpu_ready.
